// File: rtl/screen_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | screen_sequencer_pkg : shared encodings for the full-screen sequencer     |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
package screen_sequencer_pkg;

  localparam int unsigned c_pix_w = 15;
  localparam int unsigned c_tmr_w = 27;

  localparam logic [2:0] c_st_reset = 3'd0;
  localparam logic [2:0] c_st_arm   = 3'd1;
  localparam logic [2:0] c_st_sweep = 3'd2;
  localparam logic [2:0] c_st_wait  = 3'd3;
  localparam logic [2:0] c_st_play  = 3'd4;
  localparam logic [2:0] c_st_hold  = 3'd5;

  localparam logic [1:0] c_img_title    = 2'd0;
  localparam logic [1:0] c_img_flash    = 2'd1;
  localparam logic [1:0] c_img_black    = 2'd2;
  localparam logic [1:0] c_img_gameover = 2'd3;

  // Returns {show_title, show_black, show_game_over, flash}
  function automatic logic [3:0] img_decode(input logic [1:0] img);
    case (img)
      c_img_title:    img_decode = 4'b1000;
      c_img_black:    img_decode = 4'b0100;
      c_img_gameover: img_decode = 4'b0010;
      default:        img_decode = 4'b0001;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/screen_sequencer_sweep_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sweep_counter : pixel counter 0..PIXELS, wraps to 0 after terminal count  |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module sweep_counter
  import screen_sequencer_pkg::*;
#(
  parameter int unsigned PIXELS = 19200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [c_pix_w-1:0] count,
  output logic               last
);

  logic [c_pix_w-1:0] r_count;

  assign last  = (r_count == c_pix_w'(PIXELS));
  assign count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= last ? '0 : r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/screen_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | screen_sequencer : picks the next full-frame image and drives the draw    |
// | stage select lines, its address reset, the plot strobe and game_en.       |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module screen_sequencer
  import screen_sequencer_pkg::*;
#(
  parameter int unsigned H_RES        = 160,
  parameter int unsigned V_RES        = 120,
  parameter int unsigned FLASH_PERIOD = 25_000_000,
  parameter int unsigned HOLD_CYCLES  = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic game_over,
  output logic show_title,
  output logic show_black,
  output logic show_game_over,
  output logic flash,
  output logic draw_rst_n,
  output logic plot,
  output logic game_en
);

  localparam int unsigned        c_pixels     = H_RES * V_RES;
  localparam logic [c_tmr_w-1:0] c_flash_load = c_tmr_w'(FLASH_PERIOD - 1);
  localparam logic [c_tmr_w-1:0] c_hold_load  = c_tmr_w'(HOLD_CYCLES - 1);

  logic [2:0]         r_state, w_state_nxt;
  logic [1:0]         r_img, w_img_nxt;
  logic [c_tmr_w-1:0] r_tmr, w_tmr_nxt;
  logic               r_start_s1, r_start_s2, r_start_d;
  logic               w_start_edge;
  logic [c_pix_w-1:0] w_pix_count;
  logic               w_pix_last;
  logic               w_in_frame;
  logic [3:0]         w_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_s1 <= 1'b0;
      r_start_s2 <= 1'b0;
      r_start_d  <= 1'b0;
    end else begin
      r_start_s1 <= start;
      r_start_s2 <= r_start_s1;
      r_start_d  <= r_start_s2;
    end
  end

  assign w_start_edge = r_start_s2 & ~r_start_d;

  sweep_counter #(
    .PIXELS (c_pixels)
  ) u_sweep (
    .clk   (clk),
    .rst   (rst),
    .clr   (r_state == c_st_arm),
    .en    (r_state == c_st_sweep),
    .count (w_pix_count),
    .last  (w_pix_last)
  );

  // The shared down-counter is loaded on the way out of a sweep and expires at zero.
  always_comb begin
    w_state_nxt = r_state;
    w_img_nxt   = r_img;
    w_tmr_nxt   = r_tmr;
    case (r_state)
      c_st_reset: begin
        w_state_nxt = c_st_arm;
        w_img_nxt   = c_img_title;
      end
      c_st_arm: w_state_nxt = c_st_sweep;
      c_st_sweep: begin
        if (w_pix_last) begin
          case (r_img)
            c_img_black: w_state_nxt = c_st_play;
            c_img_gameover: begin
              w_state_nxt = c_st_hold;
              w_tmr_nxt   = c_hold_load;
            end
            default: begin
              w_state_nxt = c_st_wait;
              w_tmr_nxt   = c_flash_load;
            end
          endcase
        end
      end
      c_st_wait: begin
        if (w_start_edge) begin
          w_state_nxt = c_st_arm;
          w_img_nxt   = c_img_black;
        end else if (r_tmr == '0) begin
          w_state_nxt = c_st_arm;
          w_img_nxt   = (r_img == c_img_title) ? c_img_flash : c_img_title;
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end
      c_st_play: begin
        if (game_over) begin
          w_state_nxt = c_st_arm;
          w_img_nxt   = c_img_gameover;
        end
      end
      c_st_hold: begin
        if (r_tmr == '0) begin
          w_state_nxt = c_st_arm;
          w_img_nxt   = c_img_title;
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end
      default: w_state_nxt = c_st_reset;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_reset;
      r_img   <= c_img_title;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_img   <= w_img_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  // Count 0 of a sweep is the draw stage's ROM latency slot, so plot stays low there.
  assign w_in_frame = (r_state == c_st_arm) || (r_state == c_st_sweep);
  assign w_sel      = w_in_frame ? img_decode(r_img) : 4'b0000;

  assign {show_title, show_black, show_game_over, flash} = w_sel;
  assign draw_rst_n = (r_state == c_st_sweep);
  assign plot       = (r_state == c_st_sweep) && (w_pix_count != '0);
  assign game_en    = (r_state == c_st_play);

endmodule
`default_nettype wire

// File: tb/tb_screen_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_screen_sequencer : directed self-checking bench, 4x2 frame, short timers|
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_screen_sequencer;

  logic clk;
  logic rst;
  logic start;
  logic game_over;
  logic show_title, show_black, show_game_over, flash;
  logic draw_rst_n, plot, game_en;
  logic [6:0] obs;

  int checks;
  int passed;

  localparam logic [3:0] SEL_T = 4'b1000;
  localparam logic [3:0] SEL_B = 4'b0100;
  localparam logic [3:0] SEL_G = 4'b0010;
  localparam logic [3:0] SEL_F = 4'b0001;
  localparam logic [6:0] E_IDLE = 7'b0000000;
  localparam logic [6:0] E_PLAY = 7'b0000001;

  logic [6:0] exp_q[$];

  screen_sequencer #(
    .H_RES        (4),
    .V_RES        (2),
    .FLASH_PERIOD (20),
    .HOLD_CYCLES  (10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .game_over      (game_over),
    .show_title     (show_title),
    .show_black     (show_black),
    .show_game_over (show_game_over),
    .flash          (flash),
    .draw_rst_n     (draw_rst_n),
    .plot           (plot),
    .game_en        (game_en)
  );

  assign obs = {show_title, show_black, show_game_over, flash, draw_rst_n, plot, game_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {select, draw_rst_n, plot, game_en}
  function automatic logic [6:0] ev(input logic [3:0] sel, input logic drn, input logic pl);
    ev = {sel, drn, pl, 1'b0};
  endfunction

  // One full frame: ARM, latency slot, then 8 plotted pixels
  task automatic push_sweep(input logic [3:0] sel);
    exp_q.push_back(ev(sel, 1'b0, 1'b0));
    exp_q.push_back(ev(sel, 1'b1, 1'b0));
    repeat (8) exp_q.push_back(ev(sel, 1'b1, 1'b1));
  endtask

  task automatic push_n(input logic [6:0] v, input int n);
    repeat (n) exp_q.push_back(v);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs !== E_IDLE) $display("FAIL reset_state: got %b expected %b", obs, E_IDLE);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back(ev(SEL_T, 1'b0, 1'b0));
    exp_q.push_back(ev(SEL_T, 1'b1, 1'b0));
    repeat (4) exp_q.push_back(ev(SEL_T, 1'b1, 1'b1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      checks++;
      if (obs !== exp_q[0]) $display("FAIL reset_first_sweep cycle %0d: got %b expected %b", i, obs, exp_q[0]);
      else passed++;
      exp_q.delete(0);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== E_IDLE) $display("FAIL async_clear_mid_sweep: got %b expected %b", obs, E_IDLE);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_sweep(SEL_T);
    push_n(E_IDLE, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      checks++;
      if (obs !== exp_q[0]) $display("FAIL reset_restart_sweep cycle %0d: got %b expected %b", i, obs, exp_q[0]);
      else passed++;
      exp_q.delete(0);
      @(negedge clk);
    end
  endtask

  task automatic test_flash_cadence();
    apply_reset();
    push_sweep(SEL_T);
    push_n(E_IDLE, 20);
    push_sweep(SEL_F);
    push_n(E_IDLE, 20);
    push_sweep(SEL_T);
    push_n(E_IDLE, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      checks++;
      if (obs !== exp_q[0]) $display("FAIL flash_cadence cycle %0d: got %b expected %b", i, obs, exp_q[0]);
      else passed++;
      exp_q.delete(0);
      @(negedge clk);
    end
  endtask

  // Start rises in WAIT cycle 6; ARM(BLACK) shows three clocks later
  task automatic test_start();
    apply_reset();
    push_sweep(SEL_T);
    push_n(E_IDLE, 8);
    push_sweep(SEL_B);
    push_n(E_PLAY, 3);
    for (int i = 0; exp_q.size() > 0; i++) begin
      checks++;
      if (obs !== exp_q[0]) $display("FAIL start_to_play cycle %0d: got %b expected %b", i, obs, exp_q[0]);
      else passed++;
      exp_q.delete(0);
      if (i == 15) start = 1'b1;
      @(negedge clk);
    end
  endtask

  // Continues from PLAY left by test_start
  task automatic test_game_over();
    start     = 1'b0;
    game_over = 1'b1;
    push_n(E_PLAY, 1);
    push_sweep(SEL_G);
    push_n(E_IDLE, 10);
    push_sweep(SEL_T);
    push_n(E_IDLE, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      checks++;
      if (obs !== exp_q[0]) $display("FAIL game_over_hold cycle %0d: got %b expected %b", i, obs, exp_q[0]);
      else passed++;
      exp_q.delete(0);
      if (i == 1) game_over = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_start_in_sweep();
    start = 1'b0;
    apply_reset();
    push_sweep(SEL_T);
    push_n(E_IDLE, 20);
    push_sweep(SEL_F);
    push_n(E_IDLE, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      checks++;
      if (obs !== exp_q[0]) $display("FAIL start_in_sweep cycle %0d: got %b expected %b", i, obs, exp_q[0]);
      else passed++;
      exp_q.delete(0);
      if (i == 3 || i == 33) start = 1'b1;
      if (i == 5 || i == 35) start = 1'b0;
      @(negedge clk);
    end
  endtask

  // Start edge lands on the WAIT cycle whose timer is zero; game_over pulses in WAIT
  task automatic test_collision();
    start = 1'b0;
    apply_reset();
    push_sweep(SEL_T);
    push_n(E_IDLE, 20);
    push_sweep(SEL_B);
    push_n(E_PLAY, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      checks++;
      if (obs !== exp_q[0]) $display("FAIL collision cycle %0d: got %b expected %b", i, obs, exp_q[0]);
      else passed++;
      exp_q.delete(0);
      if (i == 12) game_over = 1'b1;
      if (i == 15) game_over = 1'b0;
      if (i == 27) start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // Continues from PLAY left by test_collision
  task automatic test_reset_mid_hold();
    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    checks++;
    if (obs !== ev(SEL_G, 1'b0, 1'b0)) $display("FAIL gameover_arm: got %b expected %b", obs, ev(SEL_G, 1'b0, 1'b0));
    else passed++;
    repeat (12) @(negedge clk);
    checks++;
    if (obs !== E_IDLE) $display("FAIL in_hold: got %b expected %b", obs, E_IDLE);
    else passed++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== E_IDLE) $display("FAIL hold_async_clear: got %b expected %b", obs, E_IDLE);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== ev(SEL_T, 1'b0, 1'b0)) $display("FAIL hold_reset_arm: got %b expected %b", obs, ev(SEL_T, 1'b0, 1'b0));
    else passed++;
    @(negedge clk);
    checks++;
    if (obs !== ev(SEL_T, 1'b1, 1'b0)) $display("FAIL hold_reset_sweep0: got %b expected %b", obs, ev(SEL_T, 1'b1, 1'b0));
    else passed++;
  endtask

  // Continues from the title sweep started by test_reset_mid_hold
  task automatic test_reset_mid_black();
    int n;
    repeat (9) @(negedge clk);
    start = 1'b1;
    n = 0;
    while (show_black !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 3) $display("FAIL start_latency: got %0d cycles expected 3 (show_black=%b)", n, show_black);
    else passed++;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== ev(SEL_B, 1'b1, 1'b1)) $display("FAIL black_mid_sweep: got %b expected %b", obs, ev(SEL_B, 1'b1, 1'b1));
    else passed++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== E_IDLE) $display("FAIL black_async_clear: got %b expected %b", obs, E_IDLE);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== ev(SEL_T, 1'b0, 1'b0)) $display("FAIL black_reset_arm: got %b expected %b", obs, ev(SEL_T, 1'b0, 1'b0));
    else passed++;
    @(negedge clk);
    checks++;
    if (obs !== ev(SEL_T, 1'b1, 1'b0)) $display("FAIL black_reset_sweep0: got %b expected %b", obs, ev(SEL_T, 1'b1, 1'b0));
    else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    game_over = 1'b0;
    checks    = 0;
    passed    = 0;
    test_reset();
    test_flash_cadence();
    test_start();
    test_game_over();
    test_start_in_sweep();
    test_collision();
    test_reset_mid_hold();
    test_reset_mid_black();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
